mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative HI/LO multiply/divide unit. Consumes the two register-file read
//   ports (RD1 -> A, RD2 -> B) and holds the HI/LO pair that MFHI/MFLO return
//   to the register-file write-data path. Multi-cycle; stalls issue via Busy.
// PARAMETERS
//   WIDTH  32  operand width; iteration count = WIDTH; HI/LO each WIDTH bits
// PORTS
//   clk    in   1      clock; all state updates on posedge
//   rst    in   1      synchronous, active-high reset
//   Start  in   1      op request, sampled on posedge only when Busy==0
//   MDOp   in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   A      in   WIDTH  operand 1 (rs / RD1); MTHI/MTLO source
//   B      in   WIDTH  operand 2 (rt / RD2)
//   Busy   out  1      high while a mult/div is in flight
//   Done   out  1      one-cycle pulse: HI/LO just updated by a mult/div
//   HI     out  WIDTH  high product / remainder
//   LO     out  WIDTH  low product / quotient
// BEHAVIOUR
//   Reset: state IDLE, HI=LO=0, Busy=0, Done=0, counter=0. Applies mid-op: aborts, no HI/LO write.
//   States: IDLE -> CALC -> FIX -> IDLE. Busy = (state != IDLE), registered.
//   Edge E0 (IDLE, Start=1, MDOp in 000..011): latch |A|,|B| (signed ops) or A,B
//     (unsigned ops), latch result signs, cnt<=0, state<=CALC.
//   E1..E32: one radix-2 step per edge (shift-add multiply / restoring divide),
//     cnt++; at cnt==WIDTH-1 state<=FIX.
//   E33 (FIX): apply sign fix, write HI/LO, Done<=1 for exactly one cycle, state<=IDLE.
//   Latency: Start sampled at E0 -> HI/LO valid after E33; Busy high E0+..E33 (33 cycles).
//   New Start accepted on E34 (the cycle Done is high).
//   HI/LO hold previous values throughout CALC/FIX until E33.
//   MULT: signed 2W-bit product; product negated iff sign(A)^sign(B). MULTU: unsigned.
//   DIV: LO = quotient truncated toward zero, sign = sign(A)^sign(B);
//     HI = remainder, sign = sign(A). DIVU: unsigned.
//   DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
//   Divide by zero (DIV or DIVU): full 33-cycle run, then HI=A, LO=all-ones, no sign fix.
//   MTHI/MTLO with Start=1 in IDLE: HI (resp. LO) <= A on that edge, Busy stays 0, no Done.
//   Start while Busy (any MDOp, incl. MTHI/MTLO): ignored, no state change.
//   MDOp 11x with Start: no-op, stays IDLE.
//   A/B may change after E0 without affecting the running op.
// TESTING
//   MULT A=FFFFFFFF B=00000002 -> after 33 cycles HI=FFFFFFFF LO=FFFFFFFE, Done 1 cycle.
//   MULTU A=FFFFFFFF B=00000002 -> HI=00000001 LO=FFFFFFFE; Busy exactly 33 cycles.
//   DIV A=FFFFFFF9(-7) B=2 -> LO=FFFFFFFD HI=FFFFFFFF; DIVU A=7 B=0 -> HI=7 LO=FFFFFFFF.
//   MTHI A=12345678 during DIV in flight -> ignored; then MTHI in IDLE -> HI=12345678 next edge.
//   rst at cycle 10 of a MULT -> Busy=0, HI=LO=0, no Done pulse; subsequent MULTU 3*5 -> LO=F, HI=0.
//   Back-to-back: Start on the Done cycle -> accepted; second result correct, Done 33 cycles later.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// ============================================================================
//  Module   : mult_div_unit_if
//  Purpose  : Issue/result bundle between the pipeline and the HI/LO unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       MDOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, MDOp, A, B, input Busy, Done, HI, LO);
  modport slave  (input Start, MDOp, A, B, output Busy, Done, HI, LO);
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative radix-2 multiply/divide unit holding the HI/LO pair.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             op_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod_fix;

  assign op_signed = ~bus.MDOp[0];
  assign abs_a     = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign abs_b     = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // wh/wl hold the partial product (multiply) or remainder/quotient (divide)
  assign mul_sum  = {1'b0, wh_q} + {1'b0, (wl_q[0] ? m_q : '0)};
  assign div_sh   = {wh_q, wl_q[WIDTH-1]};
  assign div_ok   = (div_sh >= {1'b0, m_q});
  assign div_diff = div_sh[WIDTH-1:0] - m_q;
  assign prod_fix = neg_q ? -{wh_q, wl_q} : {wh_q, wl_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          case (bus.MDOp)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d = bus.MDOp[1];
              neg_d    = op_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              rneg_d   = op_signed & bus.A[WIDTH-1];
              dz_d     = (bus.B == '0);
              cnt_d    = '0;
              wh_d     = '0;
              m_d      = bus.MDOp[1] ? abs_b : abs_a;
              wl_d     = bus.MDOp[1] ? abs_a : abs_b;
              state_d  = S_CALC;
            end
            3'b100:  hi_d = bus.A;
            3'b101:  lo_d = bus.A;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          wh_d = div_ok ? div_diff : div_sh[WIDTH-1:0];
          wl_d = {wl_q[WIDTH-2:0], div_ok};
        end else begin
          {wh_d, wl_d} = {mul_sum, wl_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        // Divide-by-zero leaves the remainder at |A|; the remainder sign fix restores A
        if (is_div_q) begin
          lo_d = (neg_q && !dz_q) ? -wl_q : wl_q;
          hi_d = rneg_q ? -wh_q : wh_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      wh_q     <= '0;
      wl_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      wh_q     <= wh_d;
      wl_q     <= wl_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Directed scoreboard bench for the HI/LO multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi, cur_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference built on native arithmetic; returns {HI, LO}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.Start = 1'b0;
    bus.A     = ~a;
    bus.B     = $urandom;
  endtask

  // Returns on the negedge where Done is high (or after the cycle budget)
  task automatic wait_done(input int pre, input string tag);
    int          n    = pre;
    bit          seen = 0;
    bit          held = 1;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done) begin
        seen = 1;
        break;
      end
      if (bus.Busy) n++;
      if (bus.HI !== cur_hi || bus.LO !== cur_lo) held = 0;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, n, 32'd33);
    check({tag, "_hilo_held"}, 32'(held), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_HI"}, bus.HI, e[63:32]);
      check({tag, "_LO"}, bus.LO, e[31:0]);
      cur_hi = e[63:32];
      cur_lo = e[31:0];
    end
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
    check({tag, "_idle"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.MDOp  = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    cur_hi    = '0;
    cur_lo    = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult_spec_pair", {32'(exp_q[0] == 64'hFFFF_FFFF_FFFF_FFFE)}, 32'd1);
    wait_done(0, "mult");
    finish_op("mult");

    issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(0, "multu");
    check("multu_hi_const", bus.HI, 32'h0000_0001);
    finish_op("multu");

    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(0, "div_neg");
    check("div_neg_lo_const", bus.LO, 32'hFFFF_FFFD);
    finish_op("div_neg");

    issue(3'b011, 32'h0000_0007, 32'h0000_0000);
    wait_done(0, "divu_zero");
    finish_op("divu_zero");

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, "div_ovf");
    finish_op("div_ovf");

    issue(3'b010, 32'hF000_0003, 32'h0000_0000);
    wait_done(0, "div_zero_neg");
    finish_op("div_zero_neg");

    // MTHI while a divide is in flight must be dropped
    issue(3'b010, 32'd1000, 32'hFFFF_FFFD);
    repeat (3) @(negedge clk);
    bus.Start = 1'b1;
    bus.MDOp  = 3'b100;
    bus.A     = 32'h1234_5678;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(4, "div_mthi_busy");
    finish_op("div_mthi_busy");

    bus.Start = 1'b1;
    bus.MDOp  = 3'b100;
    bus.A     = 32'h1234_5678;
    @(negedge clk);
    bus.Start = 1'b0;
    check("mthi_hi", bus.HI, 32'h1234_5678);
    check("mthi_lo", bus.LO, cur_lo);
    check("mthi_busy", 32'(bus.Busy), 32'd0);
    check("mthi_done", 32'(bus.Done), 32'd0);
    cur_hi = 32'h1234_5678;

    bus.Start = 1'b1;
    bus.MDOp  = 3'b101;
    bus.A     = 32'hCAFE_F00D;
    @(negedge clk);
    check("mtlo_lo", bus.LO, 32'hCAFE_F00D);
    check("mtlo_hi", bus.HI, cur_hi);
    cur_lo = 32'hCAFE_F00D;

    bus.MDOp  = 3'b110;
    bus.A     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.Start = 1'b0;
    check("noop_busy", 32'(bus.Busy), 32'd0);
    check("noop_hi", bus.HI, cur_hi);
    check("noop_lo", bus.LO, cur_lo);

    // Reset mid-multiply aborts without a result
    issue(3'b000, 32'h0001_0001, 32'h0002_0002);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cur_hi = '0;
    cur_lo = '0;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    seen = 0;
    repeat (36) begin
      if (bus.Done) seen = 1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);

    issue(3'b001, 32'd3, 32'd5);
    wait_done(0, "multu_3x5");
    check("multu_3x5_lo_const", bus.LO, 32'h0000_000F);
    finish_op("multu_3x5");

    // Back-to-back: second op issued in the Done cycle
    issue(3'b000, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_done(0, "b2b_first");
    issue(3'b010, 32'h8000_0001, 32'd7);
    wait_done(0, "b2b_second");
    finish_op("b2b_second");

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 2) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 100)) : $urandom);
      issue(op, a, b);
      wait_done(0, "rand");
      finish_op("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
